// File: rtl/qmult_sched.sv
// qmult_sched: round-robin scheduler sharing one combinational sign-magnitude qmult between NREQ requesters.
// Latency: accept in cycle 0, operands on mul1/mul2 from cycle 1, capture at end of cycle MUL_LAT, rsp_valid in cycle MUL_LAT+1.
// Backpressure: one operation in flight; req_ready stays low until the response handshake on rsp_ready[rsp_id] completes.
module qmult_sched #(
  parameter int N       = 16,
  parameter int Q       = 9,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*N-1:0]         req_a,
  input  logic [NREQ*N-1:0]         req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [N-1:0]              mul1,
  output logic [N-1:0]              mul2,
  input  logic [N-1:0]              mul_result,
  input  logic                      mul_ovr,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [N-1:0]              rsp_data,
  output logic                      rsp_ovr,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      busy,
  output logic                      ovr_sticky,
  input  logic                      clr_ovr
);

  localparam int IDW = $clog2(NREQ);

  // Parameter ranges the datapath and counter are sized for.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("qmult_sched: NREQ must be in 2..8");
  end
  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
    $error("qmult_sched: MUL_LAT must be in 1..15");
  end
  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("qmult_sched: Q must be in 0..N-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  cur_id;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_vld;
  logic            accept;
  logic            capture;
  logic            rsp_done;

  // Rotating-priority search: first valid requester after the last one served, wrapping around.
  always_comb begin
    int cand;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!gnt_vld && req_valid[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  // Next-state and handshake outputs; grants are only offered while idle.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    rsp_done  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_nxt          = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[cur_id] = 1'b1;
        if (rsp_ready[cur_id]) begin
          rsp_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand hold registers: loaded on accept, held until the next accept so the multiplier settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul1   <= '0;
      mul2   <= '0;
      cur_id <= '0;
    end else if (accept) begin
      mul1   <= req_a[int'(gnt_idx)*N +: N];
      mul2   <= req_b[int'(gnt_idx)*N +: N];
      cur_id <= gnt_idx;
    end
  end

  // Settle counter: counts MUL_LAT-1 down to 0 while waiting on the combinational multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= 4'(MUL_LAT - 1);
    end else if (state == S_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers: written only at capture so they stay stable through and after the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_ovr  <= 1'b0;
      rsp_id   <= '0;
    end else if (capture) begin
      rsp_data <= mul_result;
      rsp_ovr  <= mul_ovr;
      rsp_id   <= cur_id;
    end
  end

  // Round-robin pointer advances only once the response has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(NREQ - 1);
    end else if (rsp_done) begin
      last_grant <= cur_id;
    end
  end

  // Sticky overflow: a capture with overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_sticky <= 1'b0;
    end else if (capture && mul_ovr) begin
      ovr_sticky <= 1'b1;
    end else if (clr_ovr) begin
      ovr_sticky <= 1'b0;
    end
  end

  assign busy = (state != S_IDLE);

endmodule
